// File: rtl/module_scan_ctrl.sv
// Four-digit display scan controller: walks SHOW/BLANK slots per digit and
// presents a double-buffered nibble plus a gated one-hot digit enable.
module module_scan_ctrl #(
  parameter int TICKS_ON    = 27000,
  parameter int TICKS_BLANK = 270
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dig_en,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic [3:0]  nibble,
  output logic        frame_done
);

  localparam int CNT_MAX = (TICKS_ON > TICKS_BLANK) ?
                           ((TICKS_ON > 2) ? TICKS_ON : 2) :
                           ((TICKS_BLANK > 2) ? TICKS_BLANK : 2);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(TICKS_BLANK - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      data_sh_q, data_sh_d;
  logic [3:0]       mask_sh_q, mask_sh_d;
  logic [15:0]      data_act_q, data_act_d;
  logic [3:0]       mask_act_q, mask_act_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             frame_done_q, frame_done_d;
  logic             wrap_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic logic [3:0] slice4(input logic [15:0] d, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = d[3:0];
      2'd1:    n = d[7:4];
      2'd2:    n = d[11:8];
      2'd3:    n = d[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Scan sequencing: slot timing, digit advance and wrap detection.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = 2'd0;
        cnt_d = '0;
        if (en) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_d = ST_IDLE;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (TICKS_BLANK == 0) begin
            sel_d  = sel_q + 2'd1;
            wrap_s = (sel_q == 2'd3);
          end else begin
            state_d = ST_BLANK;
          end
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_d = ST_IDLE;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          sel_d   = sel_q + 2'd1;
          cnt_d   = '0;
          wrap_s  = (sel_q == 2'd3);
        end else begin
          state_d = ST_BLANK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffer: shadow always takes a load; active follows shadow only in
  // IDLE or at the frame wrap, so a load on the wrap edge is shown immediately.
  always_comb begin
    data_sh_d  = data_sh_q;
    mask_sh_d  = mask_sh_q;
    data_act_d = data_act_q;
    mask_act_d = mask_act_q;
    if (load) begin
      data_sh_d = data;
      mask_sh_d = dig_en;
    end else begin
      data_sh_d = data_sh_q;
      mask_sh_d = mask_sh_q;
    end
    if ((state_q == ST_IDLE) || wrap_s) begin
      data_act_d = data_sh_d;
      mask_act_d = mask_sh_d;
    end else begin
      data_act_d = data_act_q;
      mask_act_d = mask_act_q;
    end
  end

  // Output decode from next state so the registered outputs line up with it.
  always_comb begin
    digit_d      = 4'b0000;
    nibble_d     = 4'h0;
    frame_done_d = wrap_s;
    if (state_d == ST_SHOW) begin
      digit_d  = onehot4(sel_d) & mask_act_d;
      nibble_d = slice4(data_act_d, sel_d);
    end else begin
      digit_d  = 4'b0000;
      nibble_d = 4'h0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      cnt_q        <= '0;
      data_sh_q    <= 16'h0000;
      mask_sh_q    <= 4'h0;
      data_act_q   <= 16'h0000;
      mask_act_q   <= 4'h0;
      digit_q      <= 4'b0000;
      nibble_q     <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      data_sh_q    <= data_sh_d;
      mask_sh_q    <= mask_sh_d;
      data_act_q   <= data_act_d;
      mask_act_q   <= mask_act_d;
      digit_q      <= digit_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign digit      = digit_q;
  assign nibble     = nibble_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_module_scan_ctrl.sv
// Directed bench for module_scan_ctrl: a reset/start vector table, scan
// sequences for tear-free update, boundary load, en drop, and a no-gap build.
module tb_module_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load, en6, load6;
  logic [15:0] data, data6;
  logic [3:0]  dig_en, dig_en6;
  logic [1:0]  sel, sel6;
  logic [3:0]  digit, nibble, digit6, nibble6;
  logic        frame_done, frame_done6;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  module_scan_ctrl #(.TICKS_ON(4), .TICKS_BLANK(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dig_en(dig_en),
    .sel(sel), .digit(digit), .nibble(nibble), .frame_done(frame_done)
  );

  module_scan_ctrl #(.TICKS_ON(1), .TICKS_BLANK(0)) dut6 (
    .clk(clk), .rst(rst), .en(en6), .load(load6), .data(data6), .dig_en(dig_en6),
    .sel(sel6), .digit(digit6), .nibble(nibble6), .frame_done(frame_done6)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic [3:0]  nib;
    logic        fd;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int which, input logic [1:0] es,
                     input logic [3:0] ed, input logic [3:0] en_, input logic ef);
    logic [1:0] as_;
    logic [3:0] ad, an;
    logic       af;
    if (which == 6) begin
      as_ = sel6; ad = digit6; an = nibble6; af = frame_done6;
    end else begin
      as_ = sel; ad = digit; an = nibble; af = frame_done;
    end
    nvec++;
    if (as_ !== es || ad !== ed || an !== en_ || af !== ef) begin
      nerr++;
      $display("FAIL %s: got sel=%0d digit=%b nibble=%h fd=%b, want sel=%0d digit=%b nibble=%h fd=%b",
               nm, as_, ad, an, af, es, ed, en_, ef);
    end
  endtask

  // p = cycles since the scan started at digit 0, 6-cycle digit period.
  task automatic scan_vec(input string nm, input int p, input logic [15:0] adat,
                          input logic [3:0] amask);
    int         d, s;
    logic [3:0] ed, en_, oh;
    logic [15:0] sh;
    d  = (p / 6) % 4;
    s  = p % 6;
    oh = 4'b0001 << d;
    sh = adat >> (4 * d);
    ed  = (s < 4) ? (oh & amask) : 4'b0000;
    en_ = (s < 4) ? sh[3:0] : 4'h0;
    tick();
    chk($sformatf("%s p=%0d", nm, p), 0, 2'(d), ed, en_, (p > 0) && (p % 24 == 0));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; data = 16'h0000; dig_en = 4'h0;
    en6 = 1'b0; load6 = 1'b0; data6 = 16'h0000; dig_en6 = 4'h0;

    //        rst   en    load  data      mask  sel   digit    nib   fd
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h4321, 4'hF, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0001, 4'h1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0001, 4'h1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0001, 4'h1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0001, 4'h1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd0, 4'b0000, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 2'd1, 4'b0010, 4'h2, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load;
      data = tbl[i].data; dig_en = tbl[i].mask;
      tick();
      chk($sformatf("table[%0d]", i), 0, tbl[i].sel, tbl[i].digit, tbl[i].nib, tbl[i].fd);
    end

    // Continue the scan; load ABCD mid-frame, then 9999/0101 on the wrap edge.
    for (int p = 7; p <= 88; p++) begin
      en     = 1'b1;
      load   = (p == 31) || (p == 72);
      data   = (p == 31) ? 16'hABCD : 16'h9999;
      dig_en = (p == 31) ? 4'hF : 4'b0101;
      scan_vec("scan", p, (p < 48) ? 16'h4321 : ((p < 72) ? 16'hABCD : 16'h9999),
               (p < 72) ? 4'hF : 4'b0101);
    end
    load = 1'b0;

    // en drop during the blank after digit 2.
    en = 1'b0;
    tick();
    chk("en_drop", 0, 2'd0, 4'b0000, 4'h0, 1'b0);
    tick();
    chk("idle_hold", 0, 2'd0, 4'b0000, 4'h0, 1'b0);

    en = 1'b1;
    for (int p = 0; p <= 24; p++) begin
      scan_vec("restart", p, 16'h9999, 4'b0101);
    end
    en = 1'b0;
    tick();

    // No-gap build: one cycle per digit.
    load6 = 1'b1; data6 = 16'h8765; dig_en6 = 4'hF;
    tick();
    chk("nogap_idle", 6, 2'd0, 4'b0000, 4'h0, 1'b0);
    load6 = 1'b0; en6 = 1'b1;
    for (int p = 0; p < 13; p++) begin
      logic [3:0]  oh;
      logic [15:0] sh;
      oh = 4'b0001 << (p % 4);
      sh = 16'h8765 >> (4 * (p % 4));
      tick();
      chk($sformatf("nogap p=%0d", p), 6, 2'(p % 4), oh, sh[3:0], (p > 0) && (p % 4 == 0));
    end
    en6 = 1'b0;
    tick();
    chk("nogap_off", 6, 2'd0, 4'b0000, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
